// File: rtl/cas_overlay_pkg.sv
// Shared constants and types for the cassette-overlay character RAM logic.
// Consumers: cas_rr_arbiter, cas_chram_scheduler (optional feature macro CAS_VBLANK_GATE_EN).
package cas_overlay_pkg;

    localparam int CHRAM_AW = 12;
    localparam int RR_W     = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_t;

    localparam logic [7:0] CH_BAR_FULL  = 8'h7F;
    localparam logic [7:0] CH_BAR_EMPTY = 8'hA6;
    localparam logic [7:0] CH_GEAR_A    = 8'h2A;
    localparam logic [7:0] CH_GEAR_B    = 8'h96;

    localparam logic [CHRAM_AW-1:0] CHRAM_GEAR_L = 12'd331;
    localparam logic [CHRAM_AW-1:0] CHRAM_GEAR_R = 12'd340;
    localparam logic [CHRAM_AW-1:0] CHRAM_BAR0   = 12'd136;

    function automatic logic [RR_W-1:0] onehot_to_idx(input logic [3:0] oh);
        onehot_to_idx = '0;
        for (int k = 0; k < 4; k++) begin
            if (oh[k]) onehot_to_idx = RR_W'(k);
        end
    endfunction

endpackage

// File: rtl/cas_rr_arbiter.sv
// Combinational round-robin pick: lowest-index requester at or after rr_ptr wins.
// Result is one-hot, or all zero when nothing is requesting.
module cas_rr_arbiter
    import cas_overlay_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [RR_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] winner
);

    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (i == (int'(rr_ptr) + k) % NUM_REQ)) begin
                    winner[i] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cas_chram_scheduler.sv
// Shares the chram write port between overlay requesters; whole bursts, round-robin.
// Define CAS_VBLANK_GATE_EN to start new bursts only while vblank is high.
//
//  state | meaning
//  IDLE  | no owner; arbitrate among requesters not finishing this cycle
//  BURST | owner holds gnt; one registered write per cycle until len_m1
module cas_chram_scheduler
    import cas_overlay_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int AW      = CHRAM_AW
) (
    input  logic                  i_clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*4-1:0]  req_len_m1,
    input  logic [NUM_REQ*8-1:0]  req_data,
    input  logic                  vblank,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [3:0]            beat_idx,
    output logic [NUM_REQ-1:0]    done,
    output logic                  wr_ena,
    output logic [AW-1:0]         wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy
);

    sched_state_t       state;
    logic [RR_W-1:0]    rr_ptr;
    logic [RR_W-1:0]    win_idx;
    logic [RR_W-1:0]    arb_idx;
    logic [AW-1:0]      base;
    logic [3:0]         len_m1;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] winner;
    logic               arb_en;
    logic [AW-1:0]      sel_addr;
    logic [3:0]         sel_len;
    logic [7:0]         sel_data;

`ifdef CAS_VBLANK_GATE_EN
    assign arb_en = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign arb_en        = 1'b1;
`endif

    // A requester still pulsing done has not yet seen it, so it sits out this round.
    assign cand = req & ~done;

    cas_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (cand),
        .rr_ptr (rr_ptr),
        .winner (winner)
    );

    assign arb_idx = onehot_to_idx(4'(winner));

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == RR_W'(i)) begin
                sel_addr = req_addr[AW*i +: AW];
                sel_len  = req_len_m1[4*i +: 4];
            end
            if (win_idx == RR_W'(i)) sel_data = req_data[8*i +: 8];
        end
    end

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            win_idx  <= '0;
            base     <= '0;
            len_m1   <= '0;
            gnt      <= '0;
            beat_idx <= '0;
            done     <= '0;
            wr_ena   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wr_ena <= 1'b0;
                    done   <= '0;
                    busy   <= 1'b0;
                    if (arb_en && (|winner)) begin
                        state    <= BURST;
                        gnt      <= winner;
                        win_idx  <= arb_idx;
                        base     <= sel_addr;
                        len_m1   <= sel_len;
                        beat_idx <= '0;
                        busy     <= 1'b1;
                    end
                end
                BURST: begin
                    wr_ena  <= 1'b1;
                    wr_addr <= base + AW'(beat_idx);
                    wr_data <= sel_data;
                    busy    <= 1'b1;
                    if (beat_idx == len_m1) begin
                        done     <= gnt;
                        gnt      <= '0;
                        beat_idx <= '0;
                        rr_ptr   <= (win_idx == RR_W'(NUM_REQ - 1)) ? '0 : win_idx + RR_W'(1);
                        state    <= IDLE;
                    end else begin
                        beat_idx <= beat_idx + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cas_chram_scheduler.sv
// Bench for cas_chram_scheduler: vector table of request patterns plus hand sequences,
// with a write scoreboard fed from a requester model.
module tb_cas_chram_scheduler;
    import cas_overlay_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int AW      = 12;

    logic                  i_clk = 1'b0;
    logic                  reset_n;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*4-1:0]  req_len_m1;
    logic [NUM_REQ*8-1:0]  req_data;
    logic                  vblank;
    logic [NUM_REQ-1:0]    gnt;
    logic [3:0]            beat_idx;
    logic [NUM_REQ-1:0]    done;
    logic                  wr_ena;
    logic [AW-1:0]         wr_addr;
    logic [7:0]            wr_data;
    logic                  busy;

    cas_chram_scheduler #(.NUM_REQ(NUM_REQ), .AW(AW)) dut (
        .i_clk      (i_clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_addr   (req_addr),
        .req_len_m1 (req_len_m1),
        .req_data   (req_data),
        .vblank     (vblank),
        .gnt        (gnt),
        .beat_idx   (beat_idx),
        .done       (done),
        .wr_ena     (wr_ena),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [AW-1:0]      addr;
        logic [7:0]         data;
        logic [NUM_REQ-1:0] done;
    } wr_t;

    typedef struct {
        logic [NUM_REQ-1:0] req;
        int                 n;
        int                 order[3];
    } vec_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;
    bit   auto_drop = 1'b1;

    logic [AW-1:0] abase[NUM_REQ];
    logic [3:0]    alen[NUM_REQ];
    logic [7:0]    dbase[NUM_REQ];
    logic          dx[NUM_REQ];

    // Requester model: data depends only on the beat index the scheduler presents.
    always_comb begin
        req_addr   = '0;
        req_len_m1 = '0;
        req_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[AW*i +: AW] = abase[i];
            req_len_m1[4*i +: 4] = alen[i];
            req_data[8*i +: 8]   = dbase[i] ^ (dx[i] ? {4'h0, beat_idx} : 8'h00);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_burst(input int r);
        wr_t w;
        for (int i = 0; i <= int'(alen[r]); i++) begin
            w.addr = abase[r] + AW'(i);
            w.data = dbase[r] ^ (dx[r] ? 8'(i) : 8'h00);
            w.done = (i == int'(alen[r])) ? NUM_REQ'(1 << r) : '0;
            exp_q.push_back(w);
        end
    endtask

    task automatic step();
        @(negedge i_clk);
        if (auto_drop) begin
            for (int r = 0; r < NUM_REQ; r++) if (done[r]) req[r] = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        do begin
            step();
            n++;
        end while ((exp_q.size() != 0 || busy) && n < max);
        chk({name, "_timeout"}, 32'(n >= max), 0);
    endtask

    task automatic set_vec(input int i, input logic [NUM_REQ-1:0] r, input int n,
                           input int o0, input int o1, input int o2);
        vecs[i].req      = r;
        vecs[i].n        = n;
        vecs[i].order[0] = o0;
        vecs[i].order[1] = o1;
        vecs[i].order[2] = o2;
    endtask

    always @(negedge i_clk) begin
        if (reset_n) begin
            if (gnt != '0) chk("gnt_overlap", 32'($countones(gnt) > 1), 0);
            if (wr_ena) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {20'h0, wr_addr}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                    chk("wr_data", 32'(wr_data), 32'(mon_e.data));
                    chk("done", 32'(done), 32'(mon_e.done));
                end
            end else if (done != '0) begin
                chk("done_without_write", 32'(done), 0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;
        int order3[4];

        reset_n = 1'b0;
        req     = '0;
        vblank  = 1'b1;
        abase[0] = 12'h100;     alen[0] = 4'd2;  dbase[0] = 8'h30;       dx[0] = 1'b1;
        abase[1] = CHRAM_BAR0;  alen[1] = 4'd15; dbase[1] = CH_BAR_FULL; dx[1] = 1'b0;
        abase[2] = 12'hFFE;     alen[2] = 4'd3;  dbase[2] = 8'hC0;       dx[2] = 1'b1;

        set_vec(0, 3'b001, 1, 0, 0, 0);
        set_vec(1, 3'b010, 1, 1, 0, 0);
        set_vec(2, 3'b101, 2, 2, 0, 0);
        set_vec(3, 3'b111, 3, 1, 2, 0);
        set_vec(4, 3'b011, 2, 1, 0, 0);
        set_vec(5, 3'b100, 1, 2, 0, 0);
        set_vec(6, 3'b110, 2, 1, 2, 0);
        set_vec(7, 3'b011, 2, 0, 1, 0);

        repeat (3) @(negedge i_clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_beat_idx", 32'(beat_idx), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wr_ena", 32'(wr_ena), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;

        repeat (3) step();
        chk("idle_wr_ena", 32'(wr_ena), 0);
        chk("idle_busy", 32'(busy), 0);

        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < vecs[v].n; k++) push_burst(vecs[v].order[k]);
            req = vecs[v].req;
            wait_idle("vec", 200);
            chk("vec_req_released", 32'(req), 0);
        end

        // Single 16-beat burst: latency and busy length.
        push_burst(1);
        req[1] = 1'b1;
        step();
        chk("lat_gnt", 32'(gnt), 32'b010);
        chk("lat_wr_ena_early", 32'(wr_ena), 0);
        cnt = busy ? 1 : 0;
        step();
        chk("lat_wr_ena", 32'(wr_ena), 1);
        chk("lat_wr_addr", 32'(wr_addr), 32'(CHRAM_BAR0));
        if (busy) cnt++;
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
            if (busy) cnt++;
        end
        chk("busy_cycles", 32'(cnt), 17);
        chk("burst16_drained", 32'(exp_q.size()), 0);

        // Reset asserted at beat 5 of a 16-beat burst.
        push_burst(1);
        req[1] = 1'b1;
        n = 0;
        while (!(gnt[1] && beat_idx == 4'd5) && n < 40) begin
            step();
            n++;
        end
        chk("rst_mid_reach_beat5", 32'(n >= 40), 0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_wr_ena", 32'(wr_ena), 0);
        chk("rst_mid_gnt", 32'(gnt), 0);
        chk("rst_mid_done", 32'(done), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        exp_q.delete();
        req = '0;
        repeat (2) @(negedge i_clk);
        reset_n = 1'b1;
        step();

        // All three held with single beats: order 0,1,2,0 shows rr_ptr restarted at 0.
        alen[0] = 4'd0; alen[1] = 4'd0; alen[2] = 4'd0;
        order3[0] = 0; order3[1] = 1; order3[2] = 2; order3[3] = 0;
        for (int k = 0; k < 4; k++) push_burst(order3[k]);
        auto_drop = 1'b0;
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (gnt == '0 && n < 20) begin
                step();
                n++;
            end
            chk("rr_order", 32'(gnt), 32'(1 << order3[k]));
            if (k == 3) req = '0;
            while (gnt != '0 && n < 20) begin
                step();
                n++;
            end
        end
        auto_drop = 1'b1;
        wait_idle("rr", 50);
        repeat (3) step();
        chk("rr_no_extra", 32'(busy), 0);

        // Address wrap at the top of the RAM.
        abase[0] = 12'hFFE; alen[0] = 4'd3; dbase[0] = CH_GEAR_B; dx[0] = 1'b1;
        push_burst(0);
        req[0] = 1'b1;
        wait_idle("wrap", 50);

        // Requester drops req at beat 2; the burst still completes.
        abase[2] = 12'h200; alen[2] = 4'd3; dbase[2] = CH_BAR_EMPTY; dx[2] = 1'b0;
        push_burst(2);
        req[2] = 1'b1;
        cnt = 0;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 30) begin
            step();
            n++;
            if (done[2]) cnt++;
            if (gnt[2] && beat_idx == 4'd2) req[2] = 1'b0;
        end
        chk("drop_done_pulses", 32'(cnt), 1);
        chk("drop_drained", 32'(exp_q.size()), 0);

        // vblank behaviour.
        abase[0] = CHRAM_GEAR_L; alen[0] = 4'd3; dbase[0] = CH_GEAR_A; dx[0] = 1'b0;
        push_burst(0);
`ifdef CAS_VBLANK_GATE_EN
        vblank = 1'b0;
        req[0] = 1'b1;
        repeat (4) step();
        chk("vb_hold_gnt", 32'(gnt), 0);
        chk("vb_hold_busy", 32'(busy), 0);
        vblank = 1'b1;
        step();
        chk("vb_gnt", 32'(gnt), 32'b001);
        n = 0;
        while (!(gnt[0] && beat_idx == 4'd1) && n < 10) begin
            step();
            n++;
        end
        vblank = 1'b0;
        wait_idle("vb", 50);
        vblank = 1'b1;
`else
        vblank = 1'b0;
        req[0] = 1'b1;
        step();
        chk("vb_ignored_gnt", 32'(gnt), 32'b001);
        wait_idle("vb", 50);
        vblank = 1'b1;
`endif

        chk("final_queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
